// File: rtl/spi_slave_reg_ctrl_if.sv
// spi_slave_reg_ctrl_if: byte stream from the SPI shifter plus the register file read/write ports.
// The slave modport is the sequencer's view; master is the surrounding SPI/register environment.
interface spi_slave_reg_ctrl_if #(parameter int REG_SIZE = 8);
    logic                cs_end;
    logic [REG_SIZE-1:0] rx_data;
    logic                rx_valid;
    logic [REG_SIZE-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [REG_SIZE-1:0] reg_wr_data;
    logic [1:0]          reg_wr_addr;
    logic                reg_wr_valid;
    logic [1:0]          reg_rd_addr;
    logic [REG_SIZE-1:0] reg_rd_data;
    logic                busy;
    logic                err_cmd;
    modport slave (
        input  cs_end, rx_data, rx_valid, tx_ready, reg_rd_data,
        output tx_data, tx_valid, reg_wr_data, reg_wr_addr, reg_wr_valid, reg_rd_addr, busy, err_cmd
    );
    modport master (
        output cs_end, rx_data, rx_valid, tx_ready, reg_rd_data,
        input  tx_data, tx_valid, reg_wr_data, reg_wr_addr, reg_wr_valid, reg_rd_addr, busy, err_cmd
    );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: decodes the first SPI byte as a command and drives register file writes/reads.
// Define SPI_REG_CTRL_AUTOINC_EN to honour command bit [5] (address auto-increment for bursts).
module spi_slave_reg_ctrl #(parameter int REG_SIZE = 8) (
    input logic                  sclk,
    input logic                  rstn,
    spi_slave_reg_ctrl_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;
    state_t              r_state, w_state_nxt;
    logic [1:0]          r_addr, w_addr_nxt;
    logic                r_inc, w_inc_nxt;
    logic                r_wr_valid, w_wr_valid_nxt;
    logic [1:0]          r_wr_addr, w_wr_addr_nxt;
    logic [REG_SIZE-1:0] r_wr_data, w_wr_data_nxt;
    logic                r_err, w_err_nxt;
    logic                w_cmd_inc;
`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign w_cmd_inc = io_bus.rx_data[5];
`else
    assign w_cmd_inc = 1'b0;
`endif
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_addr     <= 2'd0;
            r_inc      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 2'd0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_inc      <= w_inc_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_err      <= w_err_nxt;
        end
    end
    // cs_end overrides everything, including a byte arriving in the same cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_inc_nxt      = r_inc;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_err_nxt      = 1'b0;
        if (io_bus.cs_end) begin
            w_state_nxt = IDLE;
            w_inc_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: if (io_bus.rx_valid) begin
                    w_state_nxt = io_bus.rx_data[7] ? (io_bus.rx_data[6] ? READ : WRITE) : DISCARD;
                    w_err_nxt   = !io_bus.rx_data[7];
                    w_addr_nxt  = io_bus.rx_data[1:0];
                    w_inc_nxt   = w_cmd_inc;
                end
                WRITE: if (io_bus.rx_valid) begin
                    w_wr_valid_nxt = 1'b1;
                    w_wr_addr_nxt  = r_addr;
                    w_wr_data_nxt  = io_bus.rx_data;
                    w_addr_nxt     = r_addr + {1'b0, r_inc};
                end
                READ: if (io_bus.tx_ready) w_addr_nxt = r_addr + {1'b0, r_inc};
                default: ;
            endcase
        end
    end
    assign io_bus.tx_valid     = r_state == READ;
    assign io_bus.tx_data      = io_bus.reg_rd_data;
    assign io_bus.reg_rd_addr  = r_addr;
    assign io_bus.reg_wr_valid = r_wr_valid;
    assign io_bus.reg_wr_addr  = r_wr_addr;
    assign io_bus.reg_wr_data  = r_wr_data;
    assign io_bus.busy         = r_state != IDLE;
    assign io_bus.err_cmd      = r_err;
endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// tb_spi_slave_reg_ctrl: directed and randomized transactions checked against a transaction-level model.
// Honours SPI_REG_CTRL_AUTOINC_EN the same way as the design.
module tb_spi_slave_reg_ctrl;
    localparam int W = 8;
`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    logic sclk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int exp_err = 0;
    logic [W-1:0] regs [4];
    logic [W-1:0] mdl [4];
    logic [W+1:0] obs_wr [$];
    logic [W+1:0] exp_wr [$];

    spi_slave_reg_ctrl_if #(.REG_SIZE(W)) bus ();
    spi_slave_reg_ctrl #(.REG_SIZE(W)) dut (.sclk(sclk), .rstn(rstn), .io_bus(bus));

    always #5 sclk = ~sclk;
    assign bus.reg_rd_data = regs[bus.reg_rd_addr];

    // register file stand-in and output monitor, sampled mid-cycle
    always @(negedge sclk) begin
        if (bus.reg_wr_valid === 1'b1) begin
            obs_wr.push_back({bus.reg_wr_addr, bus.reg_wr_data});
            regs[bus.reg_wr_addr] = bus.reg_wr_data;
        end
        if (bus.err_cmd === 1'b1) err_pulses++;
    end

    function automatic int step(input logic [7:0] cmd);
        return (AUTOINC && cmd[5]) ? 1 : 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic send(input logic [W-1:0] b, input logic cs);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        bus.cs_end = cs;
        @(negedge sclk);
        bus.rx_valid = 1'b0;
        bus.cs_end = 1'b0;
    endtask

    task automatic end_txn();
        bus.cs_end = 1'b1;
        @(negedge sclk);
        bus.cs_end = 1'b0;
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        exp_wr.delete();
        err_pulses = 0;
        exp_err = 0;
    endtask

    // Stimulus plus model: a write command writes byte i to (start + i*step) mod 4;
    // a byte coinciding with cs_end is dropped; opcodes 00/01 raise one error and access nothing.
    task automatic write_txn(input logic [7:0] cmd, input logic [W-1:0] d[$], input bit collide, input bit gaps);
        int a;
        send(cmd, 1'b0);
        if (!cmd[7]) exp_err++;
        foreach (d[i]) begin
            if (collide && i == d.size() - 1) begin
                send(d[i], 1'b1);
            end else begin
                send(d[i], 1'b0);
                if (cmd[7:6] == 2'b10) begin
                    a = (int'(cmd[1:0]) + i * step(cmd)) % 4;
                    exp_wr.push_back({2'(a), d[i]});
                    mdl[a] = d[i];
                end
                if (gaps) idle($urandom_range(0, 1));
            end
        end
        if (!(collide && d.size() > 0)) end_txn();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle(2);
        checks++; if (bus.reg_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", bus.reg_wr_valid); end
        rstn = 1'b1;
        idle(1);
        checks++; if (bus.reg_wr_addr !== 2'd0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", bus.reg_wr_addr); end
        checks++; if (bus.reg_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.reg_wr_data); end
        checks++; if (bus.reg_rd_addr !== 2'd0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", bus.reg_rd_addr); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        checks++; if (bus.tx_data !== regs[0]) begin errors++; $display("FAIL reset_tx_data: got %h want %h", bus.tx_data, regs[0]); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.err_cmd !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_cmd); end
    endtask

    task automatic test_single_write();
        logic [W-1:0] d[$];
        clear_obs();
        send(8'h82, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b want 1", bus.busy); end
        send(8'hA5, 1'b0);
        end_txn();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_lo: got %b want 0", bus.busy); end
        idle(2);
        checks++; if (obs_wr.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", obs_wr.size()); end
        checks++; if (obs_wr.size() > 0 && obs_wr[0] !== {2'd2, 8'hA5}) begin errors++; $display("FAIL single_write: got %h want %h", obs_wr[0], {2'd2, 8'hA5}); end
        checks++; if (err_pulses != 0) begin errors++; $display("FAIL single_err: got %0d want 0", err_pulses); end
        mdl[2] = 8'hA5;
        d.delete();
    endtask

    task automatic test_burst_write();
        logic [W-1:0] d[$];
        clear_obs();
        d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
        write_txn(8'hA3, d, 1'b0, 1'b0);
        idle(2);
        checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL burst_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++; if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL burst_write[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
        checks++; if (regs[3] !== mdl[3]) begin errors++; $display("FAIL burst_reg3: got %h want %h", regs[3], mdl[3]); end
    endtask

    task automatic test_read();
        logic [7:0] cmds [2];
        int a;
        cmds[0] = 8'hE1;
        cmds[1] = 8'hC1;
        for (int i = 0; i < 4; i++) begin
            regs[i] = 8'(8'h10 * (i + 1));
            mdl[i] = regs[i];
        end
        foreach (cmds[c]) begin
            send(cmds[c], 1'b0);
            for (int k = 0; k < 3; k++) begin
                a = (int'(cmds[c][1:0]) + k * step(cmds[c])) % 4;
                checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL read_tx_valid %h/%0d: got %b want 1", cmds[c], k, bus.tx_valid); end
                checks++; if (bus.tx_data !== mdl[a]) begin errors++; $display("FAIL read_tx_data %h/%0d: got %h want %h", cmds[c], k, bus.tx_data, mdl[a]); end
                bus.tx_ready = 1'b1;
                @(negedge sclk);
                bus.tx_ready = 1'b0;
            end
            end_txn();
            checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL read_end %h: got %b want 0", cmds[c], bus.tx_valid); end
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] d[$];
        clear_obs();
        d.push_back(8'hFF);
        write_txn(8'h41, d, 1'b0, 1'b0);
        d.delete();
        d.push_back(8'h5A);
        write_txn(8'h80, d, 1'b0, 1'b0);
        idle(2);
        checks++; if (err_pulses != 1) begin errors++; $display("FAIL illegal_err_cycles: got %0d want 1", err_pulses); end
        checks++; if (obs_wr.size() != 1) begin errors++; $display("FAIL illegal_count: got %0d want 1", obs_wr.size()); end
        checks++; if (obs_wr.size() > 0 && obs_wr[0] !== {2'd0, 8'h5A}) begin errors++; $display("FAIL illegal_write: got %h want %h", obs_wr[0], {2'd0, 8'h5A}); end
    endtask

    task automatic test_cs_collision();
        logic [W-1:0] d[$];
        clear_obs();
        d.push_back(8'h01); d.push_back(8'h02);
        write_txn(8'hA0, d, 1'b1, 1'b0);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL collide_busy: got %b want 0", bus.busy); end
        send(8'hC0, 1'b0);
        checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL collide_read_valid: got %b want 1", bus.tx_valid); end
        checks++; if (bus.tx_data !== mdl[0]) begin errors++; $display("FAIL collide_read_data: got %h want %h", bus.tx_data, mdl[0]); end
        end_txn();
        idle(2);
        checks++; if (obs_wr.size() != 1) begin errors++; $display("FAIL collide_count: got %0d want 1", obs_wr.size()); end
        checks++; if (obs_wr.size() > 0 && obs_wr[0] !== {2'd0, 8'h01}) begin errors++; $display("FAIL collide_write: got %h want %h", obs_wr[0], {2'd0, 8'h01}); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send(8'h81, 1'b0);
        bus.rx_data = 8'h77;
        bus.rx_valid = 1'b1;
        #2 rstn = 1'b0;
        @(negedge sclk);
        bus.rx_valid = 1'b0;
        idle(1);
        checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL rstmid_wr: got %0d writes want 0", obs_wr.size()); end
        checks++; if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.err_cmd !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b tx_valid=%b err=%b want 0", bus.busy, bus.tx_valid, bus.err_cmd); end
        checks++; if (bus.reg_wr_addr !== 2'd0 || bus.reg_wr_data !== 8'h00 || bus.reg_rd_addr !== 2'd0) begin errors++; $display("FAIL rstmid_regs: got wa=%h wd=%h ra=%h want 0", bus.reg_wr_addr, bus.reg_wr_data, bus.reg_rd_addr); end
        rstn = 1'b1;
        idle(1);
        send(8'hC2, 1'b0);
        checks++; if (bus.tx_valid !== 1'b1 || bus.reg_rd_addr !== 2'd2) begin errors++; $display("FAIL rstmid_cmd: got tx_valid=%b addr=%h want 1/2", bus.tx_valid, bus.reg_rd_addr); end
        end_txn();
    endtask

    task automatic test_random();
        logic [W-1:0] d[$];
        logic [7:0] cmd;
        int a, k, m;
        bit rdy;
        clear_obs();
        for (int t = 0; t < 60; t++) begin
            cmd = 8'($urandom);
            if (cmd[7:6] == 2'b11) begin
                send(cmd, 1'b0);
                k = 0;
                m = $urandom_range(1, 6);
                repeat (m) begin
                    a = (int'(cmd[1:0]) + k * step(cmd)) % 4;
                    checks++;
                    if (bus.tx_valid !== 1'b1 || bus.reg_rd_addr !== 2'(a) || bus.tx_data !== mdl[a]) begin
                        errors++;
                        $display("FAIL rand_read cmd=%h k=%0d: got v=%b a=%h d=%h want 1/%h/%h", cmd, k, bus.tx_valid, bus.reg_rd_addr, bus.tx_data, a, mdl[a]);
                    end
                    rdy = 1'($urandom_range(0, 1));
                    bus.tx_ready = rdy;
                    bus.rx_valid = 1'($urandom_range(0, 1));
                    bus.rx_data = 8'($urandom);
                    @(negedge sclk);
                    bus.tx_ready = 1'b0;
                    bus.rx_valid = 1'b0;
                    if (rdy) k++;
                end
                end_txn();
            end else begin
                d.delete();
                repeat ($urandom_range(0, 4)) d.push_back(8'($urandom));
                write_txn(cmd, d, ($urandom_range(0, 3) == 0), 1'b1);
            end
            idle($urandom_range(0, 2));
        end
        idle(2);
        checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++; if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rand_write[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
        checks++; if (err_pulses != exp_err) begin errors++; $display("FAIL rand_err: got %0d want %0d", err_pulses, exp_err); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (regs[i] !== mdl[i]) begin errors++; $display("FAIL rand_reg[%0d]: got %h want %h", i, regs[i], mdl[i]); end
        end
    endtask

    initial begin
        bus.cs_end = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            regs[i] = '0;
            mdl[i] = '0;
        end
        test_reset();
        test_single_write();
        test_burst_write();
        test_read();
        test_illegal();
        test_cs_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
